// File: rtl/din_deserializer_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
package din_deserializer_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic {
    FILL = 1'b0,  // accepting serial bits
    HOLD = 1'b1   // complete word parked, waiting for the output register
  } state_e;

endpackage

// File: rtl/din_deserializer.sv
// MSB-first serial deserializer with a one-word holding stage, valid/ready output
// handshake, and a sticky overflow flag plus a saturating count of dropped bits.
module din_deserializer
  import din_deserializer_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stb,
  input  logic              di,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [WIDTH-1:0]    dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic                out_free;
  logic [WIDTH-1:0]    next_word;

  assign out_free  = !valid_q || dout_ready;
  assign next_word = {shreg_q[WIDTH-2:0], di};

  // NOTE: every variable gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;

    // A handshake empties the output register unless a load below refills it.
    if (valid_q && dout_ready) valid_d = 1'b0;

    if (state_q == FILL) begin
      if (stb) begin
        shreg_d = next_word;
        if (cnt_q == LAST_BIT) begin
          if (out_free) begin
            dout_d  = next_word;
            valid_d = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else begin
      // Bits arriving in HOLD are lost, including on the edge that leaves HOLD.
      if (stb) begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + 1'b1;
      end
      if (out_free) begin
        dout_d  = shreg_q;
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = FILL;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_din_deserializer.sv
// Directed bench for din_deserializer (WIDTH=8): expected words go into a scoreboard
// queue at issue time and a monitor pops them on every output handshake.
module tb_din_deserializer;
  import din_deserializer_pkg::*;

  localparam int WIDTH  = 8;
  localparam int DROP_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stb;
  logic              di;
  logic [WIDTH-1:0]  dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  din_deserializer #(.WIDTH(WIDTH), .DROP_W(DROP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stb        (stb),
    .di         (di),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after a rising edge and are sampled on the next one.
  task automatic bit_cycle(input logic s, input logic d);
    stb = s;
    di  = d;
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) bit_cycle(1'b1, w[i]);
    stb = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bit_cycle(1'b0, 1'b0);
  endtask

  // Monitor: on the falling edge, whatever is valid and ready will be accepted next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(dout), 64'hDEAD);
        end else begin
          check("scoreboard_word", 64'(dout), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    rst_n      = 1'b0;
    stb        = 1'b0;
    di         = 1'b0;
    dout_ready = 1'b1;

    // Reset state
    #1;
    check("rst_dout",     64'(dout),       64'h0);
    check("rst_valid",    64'(dout_valid), 64'h0);
    check("rst_overflow", 64'(overflow),   64'h0);
    check("rst_drop",     64'(drop_count), 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Basic assembly: 1,0,1,0,0,1,0,1 -> A5
    exp_q.push_back(8'hA5);
    send_word(8'hA5);
    check("basic_valid", 64'(dout_valid), 64'h1);
    check("basic_dout",  64'(dout),       64'hA5);
    idle(1);
    check("basic_valid_drop", 64'(dout_valid), 64'h0);

    // Gapped strobes; di toggles while stb=0 and must be ignored
    exp_q.push_back(8'hA5);
    w = 8'hA5;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      repeat ($urandom_range(0, 3)) bit_cycle(1'b0, 1'($urandom_range(0, 1)));
      bit_cycle(1'b1, w[i]);
    end
    stb = 1'b0;
    check("gap_valid", 64'(dout_valid), 64'h1);
    check("gap_dout",  64'(dout),       64'hA5);
    idle(2);
    check("gap_valid_drop", 64'(dout_valid), 64'h0);
    check("gap_no_drops",   64'(drop_count), 64'h0);

    // Backpressure: 3C waits in dout, C3 parks in HOLD, 3 bits dropped
    dout_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_word(8'h3C);
    check("bp_first_valid", 64'(dout_valid), 64'h1);
    check("bp_first_dout",  64'(dout),       64'h3C);
    exp_q.push_back(8'hC3);
    send_word(8'hC3);
    check("bp_dout_stable", 64'(dout),          64'h3C);
    check("bp_in_hold",     64'(dut.state_q),   64'(HOLD));
    check("bp_no_ovf_yet",  64'(overflow),      64'h0);
    for (int i = 0; i < 3; i++) bit_cycle(1'b1, 1'b1);
    stb = 1'b0;
    check("bp_overflow", 64'(overflow),   64'h1);
    check("bp_drop3",    64'(drop_count), 64'h3);
    check("bp_still_3C", 64'(dout),       64'h3C);
    dout_ready = 1'b1;
    idle(1);
    check("bp_next_valid", 64'(dout_valid), 64'h1);
    check("bp_next_dout",  64'(dout),       64'hC3);
    idle(1);
    check("bp_drained", 64'(dout_valid), 64'h0);

    // Back-to-back words on a continuous strobe
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 2 * WIDTH; i++) begin
      w = (i < WIDTH) ? 8'h01 : 8'hFF;
      bit_cycle(1'b1, w[WIDTH - 1 - (i % WIDTH)]);
      check("b2b_valid", 64'(dout_valid), 64'((i == WIDTH - 1) || (i == 2 * WIDTH - 1)));
    end
    stb = 1'b0;
    check("b2b_dout_last", 64'(dout),       64'hFF);
    check("b2b_drops",     64'(drop_count), 64'h3);
    idle(1);

    // Mid-word asynchronous reset
    for (int i = 0; i < 5; i++) bit_cycle(1'b1, 1'b1);
    stb = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_dout",     64'(dout),       64'h0);
    check("mrst_valid",    64'(dout_valid), 64'h0);
    check("mrst_overflow", 64'(overflow),   64'h0);
    check("mrst_drop",     64'(drop_count), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    exp_q.push_back(8'h5A);
    send_word(8'h5A);
    check("mrst_valid_after", 64'(dout_valid), 64'h1);
    check("mrst_dout_after",  64'(dout),       64'h5A);
    idle(1);

    // Saturation of drop_count
    dout_ready = 1'b0;
    exp_q.push_back(8'h96);
    send_word(8'h96);
    exp_q.push_back(8'h69);
    send_word(8'h69);
    for (int i = 0; i < 300; i++) bit_cycle(1'b1, 1'(i));
    stb = 1'b0;
    check("sat_drop",     64'(drop_count), 64'd255);
    check("sat_overflow", 64'(overflow),   64'h1);
    check("sat_dout",     64'(dout),       64'h96);
    dout_ready = 1'b1;
    idle(3);
    check("sat_drained",  64'(dout_valid), 64'h0);
    check("sat_drop_kept", 64'(drop_count), 64'd255);

    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/din_deserializer.md
DIN_DESERIALIZER -- requirements
Module: din_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the number of serial bits per assembled word (legal range 2..64).
REQ-002 SHALL have parameter DROP_W, default 8, meaning the width of the dropped-bit counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  the reset, asynchronous and active-low.
REQ-005 SHALL have port stb  input  1  serial bit strobe; di is sampled only on edges where stb=1.
REQ-006 SHALL have port di  input  1  serial data bit.
REQ-007 SHALL have port dout  output  WIDTH  the assembled word, valid while dout_valid=1.
REQ-008 SHALL have port dout_valid  output  1  the output word is pending.
REQ-009 SHALL have port dout_ready  input  1  the consumer accepts dout on an edge where dout_valid=1 and dout_ready=1.
REQ-010 SHALL have port overflow  output  1  sticky flag: at least one strobed bit was dropped.
REQ-011 SHALL have port drop_count  output  DROP_W  number of dropped bits, saturating.

Function
REQ-012 SHALL shift MSB-first: on a sampled edge, shreg <= {shreg[WIDTH-2:0], di}, so the first bit of a word ends at dout[WIDTH-1].
REQ-013 SHALL keep a bit counter 0..WIDTH-1 that increments on each sampled bit in state FILL.
REQ-014 SHALL use a two-state FSM: FILL (accepting bits) and HOLD (complete word waiting for the output register).
REQ-015 SHALL treat the output register as free on an edge when dout_valid=0, or when dout_valid=1 and dout_ready=1.
REQ-016 SHALL, on the sampled edge that delivers bit WIDTH-1 in FILL with the output register free, load the completed word (including that bit) into dout, set dout_valid, zero the counter, and remain in FILL; dout_valid is therefore high on the cycle after the final strobe.
REQ-017 SHALL, on that same final edge with the output register not free, store the completed word in shreg and go to HOLD.
REQ-018 SHALL, in HOLD, load shreg into dout and set dout_valid on the first edge where the output register is free, zero the counter, and return to FILL.
REQ-019 SHALL drop any strobed bit that arrives in HOLD, including one on the edge that leaves HOLD; each dropped bit sets overflow and increments drop_count.
REQ-020 SHALL saturate drop_count at 2^DROP_W-1.
REQ-021 SHALL clear dout_valid on a handshake edge unless a new word is loaded on the same edge; a simultaneous handshake and new load yields back-to-back valid words with no bubble.
REQ-022 SHALL hold dout stable while dout_valid=1 and not accepted.
REQ-023 SHALL leave the bit counter and shreg unchanged on edges with stb=0.

Reset
REQ-024 SHALL, while rst_n=0, force dout=0, dout_valid=0, overflow=0, drop_count=0, shreg=0, counter=0, and state FILL, independent of clk.
REQ-025 SHALL discard a partially assembled word on reset, so the first sampled bit after reset deassertion is bit 0 of a new word.
REQ-026 SHALL have overflow and drop_count cleared only by reset.

Structure
REQ-027 SHALL place the FSM state enum (FILL, HOLD) and a default-WIDTH constant in the shared fuzzer package.
REQ-028 SHALL be a single module with no sub-modules; the saturating counter is inline.

Verification (WIDTH=8, DROP_W=8)
REQ-029 SHALL verify basic assembly: 8 strobes carrying 1,0,1,0,0,1,0,1 with dout_ready=1 -> dout=8'hA5 and dout_valid=1 on the cycle after the 8th strobe, deasserting the next cycle.
REQ-030 SHALL verify gapped strobes: the same 8 bits with stb=0 cycles interleaved randomly -> dout=8'hA5 with no extra bits.
REQ-031 SHALL verify backpressure: dout_ready=0, send 8'h3C then 8'hC3 -> dout stays 8'h3C and the FSM enters HOLD; 3 further strobes -> overflow=1 and drop_count=3; raise dout_ready -> 8'h3C accepted, then 8'hC3 valid on the next cycle.
REQ-032 SHALL verify back-to-back words: continuous stb, dout_ready=1, send 8'h01 then 8'hFF -> two valid pulses 8 cycles apart, no drops.
REQ-033 SHALL verify mid-word reset: 5 bits sent, assert rst_n=0 asynchronously, then send 8'h5A -> dout=8'h5A with all outputs zero during reset.
REQ-034 SHALL verify saturation: hold dout_ready=0 with a full pending word and 300 strobes -> drop_count=255 and overflow=1.
